// File: rtl/i2c_pkg.sv
// Shared I2C command encodings, reader FSM state type and MPU6050 register map.
package i2c_pkg;

    // Byte-level command codes understood by the I2C controller.
    typedef enum logic [2:0] {
        CmdStart    = 3'd0,
        CmdWrite    = 3'd1,
        CmdReadAck  = 3'd2,
        CmdReadNack = 3'd3,
        CmdStop     = 3'd4
    } cmd_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StIssue,
        StWaitRsp,
        StAbort,
        StPublish
    } state_t;

    // MPU6050 register addresses.
    localparam logic [7:0] PWR_MGMT_1  = 8'h6B;
    localparam logic [7:0] GYRO_XOUT_H = 8'h43;

    // Burst-read sequence bookkeeping.
    localparam logic [3:0] LAST_STEP = 4'd11;

    typedef struct packed {
        cmd_op_t    op;
        logic [7:0] wdata;
    } cmd_t;

    // Step-to-command lookup for the 12-step gyro burst read.
    function automatic cmd_t step_cmd(input logic [3:0] step,
                                      input logic [6:0] dev_addr,
                                      input logic [7:0] start_reg);
        cmd_t c;
        c.op    = CmdStop;
        c.wdata = 8'h00;
        case (step)
            4'd0, 4'd3: c.op = CmdStart;
            4'd1: begin
                c.op    = CmdWrite;
                c.wdata = {dev_addr, 1'b0};
            end
            4'd2: begin
                c.op    = CmdWrite;
                c.wdata = start_reg;
            end
            4'd4: begin
                c.op    = CmdWrite;
                c.wdata = {dev_addr, 1'b1};
            end
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: c.op = CmdReadAck;
            4'd10: c.op = CmdReadNack;
            default: c.op = CmdStop;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mpu6050_gyro_reader.sv
// Periodically burst-reads the MPU6050 gyro registers through a byte-level
// I2C command interface and publishes the three axes together.
module mpu6050_gyro_reader
    import i2c_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter logic [6:0]  DEV_ADDR   = 7'h68,
    parameter logic [7:0]  START_REG  = GYRO_XOUT_H
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    input  logic        rsp_nack,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        sample_valid,
    output logic        bus_error,
    output logic [7:0]  err_count
);

    state_t      state_q, state_d;
    logic [31:0] timer_q;
    logic [3:0]  step_q;
    logic        abort_sent_q;   // STOP of the abort sequence has been accepted
    logic [47:0] bytes_q;        // read bytes shifted in, b0 ends up in [47:40]
    cmd_t        cur_cmd;
    logic        tick;
    logic        rsp_is_nack;
    logic        step_is_read;

    assign cur_cmd      = step_cmd(step_q, DEV_ADDR, START_REG);
    assign tick         = (state_q != StIdle) && (timer_q == SAMPLE_DIV - 32'd1);
    assign rsp_is_nack  = rsp_nack && (cur_cmd.op == CmdWrite);
    assign step_is_read = (cur_cmd.op == CmdReadAck) || (cur_cmd.op == CmdReadNack);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a finished transaction only returns to IDLE here.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (init_done) state_d = StWaitTick;
            end
            StWaitTick: begin
                if (!init_done) state_d = StIdle;
                else if (tick)  state_d = StIssue;
            end
            StIssue: begin
                if (cmd_ready) state_d = StWaitRsp;
            end
            StWaitRsp: begin
                if (rsp_valid) begin
                    if (rsp_is_nack)               state_d = StAbort;
                    else if (step_q == LAST_STEP)  state_d = StPublish;
                    else                           state_d = StIssue;
                end
            end
            StAbort: begin
                if (abort_sent_q && rsp_valid) state_d = init_done ? StWaitTick : StIdle;
            end
            StPublish: begin
                state_d = init_done ? StWaitTick : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Command interface outputs; payload is a pure function of state and step.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_op    = CmdStop;
        cmd_wdata = 8'h00;
        case (state_q)
            StIssue: begin
                cmd_valid = 1'b1;
                cmd_op    = cur_cmd.op;
                cmd_wdata = cur_cmd.wdata;
            end
            StAbort: cmd_valid = !abort_sent_q;
            default: ;
        endcase
    end

    // Sample timer, step counter, byte capture, published results and error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q      <= '0;
            step_q       <= '0;
            abort_sent_q <= 1'b0;
            bytes_q      <= '0;
            gyro_x       <= '0;
            gyro_y       <= '0;
            gyro_z       <= '0;
            sample_valid <= 1'b0;
            bus_error    <= 1'b0;
            err_count    <= '0;
        end else begin
            sample_valid <= 1'b0;
            bus_error    <= 1'b0;
            // Free-running while active; ticks outside WAIT_TICK are simply lost.
            timer_q <= (state_q == StIdle || tick) ? '0 : timer_q + 32'd1;
            case (state_q)
                StWaitTick: begin
                    if (tick) step_q <= '0;
                end
                StWaitRsp: begin
                    if (rsp_valid) begin
                        if (rsp_is_nack) begin
                            abort_sent_q <= 1'b0;
                        end else begin
                            if (step_is_read) bytes_q <= {bytes_q[39:0], rsp_rdata};
                            if (step_q != LAST_STEP) step_q <= step_q + 4'd1;
                        end
                    end
                end
                StAbort: begin
                    if (!abort_sent_q) begin
                        if (cmd_ready) abort_sent_q <= 1'b1;
                    end else if (rsp_valid) begin
                        bus_error <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end
                end
                StPublish: begin
                    gyro_x       <= bytes_q[47:32];
                    gyro_y       <= bytes_q[31:16];
                    gyro_z       <= bytes_q[15:0];
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
